// File: rtl/ram_line_xfer.sv
`timescale 1ns/1ps
// Cache-line <-> RAM word engine: queues line requests and splits each into WORDS word accesses.
// Latency: with zero-wait RAM, cache_ack is high in the cycle after edge T+2*WORDS (push at T).
// Backpressure: cache_ready drops when the queue is full; a RAM word waits for ram_ack or the timeout.
module ram_line_xfer #(
    parameter int ADDR_SIZE  = 13,
    parameter int LINE_WIDTH = 64,
    parameter int WORD_SIZE  = 16,
    parameter int QDEPTH     = 2,
    parameter int CWF        = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  not_reset,
    input  logic                  cache_avalid,
    input  logic                  cache_rnw,
    input  logic [ADDR_SIZE-1:0]  cache_addr,
    input  logic [LINE_WIDTH-1:0] cache_wdata,
    output logic                  cache_ready,
    output logic [LINE_WIDTH-1:0] cache_rdata,
    output logic                  cache_ack,
    output logic                  cache_err,
    input  logic [WORD_SIZE-1:0]  ram_rdata,
    input  logic                  ram_ack,
    output logic                  ram_avalid,
    output logic                  ram_rnw,
    output logic [ADDR_SIZE-1:0]  ram_addr,
    output logic [WORD_SIZE-1:0]  ram_wdata
);

    localparam int WORDS = LINE_WIDTH / WORD_SIZE;
    localparam int OFS   = $clog2(WORDS);
    localparam int PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW    = $clog2(QDEPTH + 1);
    localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    typedef struct packed {
        logic                  rnw;
        logic [ADDR_SIZE-1:0]  addr;
        logic [LINE_WIDTH-1:0] wdata;
    } req_t;

    req_t                      q_mem [QDEPTH];
    req_t                      head;
    logic [PW-1:0]             wr_ptr, rd_ptr;
    logic [CW-1:0]             q_cnt;
    logic                      push, pop;

    logic [2:0]                state;
    logic                      cur_rnw;
    logic [ADDR_SIZE-OFS-1:0]  cur_hi;
    logic [OFS-1:0]            cur_start, idx, off;
    logic [LINE_WIDTH-1:0]     cur_wdata, rbuf, rbuf_upd;
    logic [TW-1:0]             tcnt;
    logic                      last, timeout_hit;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign cache_ready = (q_cnt != CW'(QDEPTH));
    assign push        = cache_avalid & cache_ready;
    assign pop         = (state == S_IDLE) && (q_cnt != '0);
    assign head        = q_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            q_mem[wr_ptr] <= '{rnw: cache_rnw, addr: cache_addr, wdata: cache_wdata};
    end

    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_cnt  <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   q_cnt <= q_cnt + CW'(1);
                2'b01:   q_cnt <= q_cnt - CW'(1);
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    // Offset add is OFS bits wide so it wraps within the line and never touches cur_hi.
    assign off         = cur_start + idx;
    assign last        = (idx == OFS'(WORDS - 1));
    assign timeout_hit = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT - 1));

    assign ram_avalid = (state == S_REQ);
    assign ram_rnw    = cur_rnw;
    assign ram_addr   = {cur_hi, off};
    assign ram_wdata  = cur_wdata[int'(off) * WORD_SIZE +: WORD_SIZE];
    assign cache_ack  = (state == S_DONE) || (state == S_ERR);
    assign cache_err  = (state == S_ERR);

    always_comb begin
        rbuf_upd = rbuf;
        rbuf_upd[int'(off) * WORD_SIZE +: WORD_SIZE] = ram_rdata;
    end

    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            state       <= S_IDLE;
            cur_rnw     <= 1'b0;
            cur_hi      <= '0;
            cur_start   <= '0;
            cur_wdata   <= '0;
            idx         <= '0;
            tcnt        <= '0;
            rbuf        <= '0;
            cache_rdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        cur_rnw   <= head.rnw;
                        cur_hi    <= head.addr[ADDR_SIZE-1:OFS];
                        cur_start <= (head.rnw && CWF != 0) ? head.addr[OFS-1:0] : '0;
                        cur_wdata <= head.wdata;
                        idx       <= '0;
                        tcnt      <= '0;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (ram_ack) begin
                        if (cur_rnw)
                            rbuf <= rbuf_upd;
                        if (last) begin
                            if (cur_rnw)
                                cache_rdata <= rbuf_upd;
                            state <= S_DONE;
                        end else begin
                            state <= S_GAP;
                        end
                    end else if (timeout_hit) begin
                        state <= S_ERR;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_GAP: begin
                    idx   <= idx + OFS'(1);
                    tcnt  <= '0;
                    state <= S_REQ;
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_line_xfer.sv
`timescale 1ns/1ps
// Bench: two instances (CWF=1 and CWF=0, TIMEOUT=8) share cache stimulus and RAM ack timing;
// each has its own RAM array and scoreboard fed by a line-level reference model.
module tb_ram_line_xfer;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        not_reset = 1'b0;
    logic        cache_avalid = 1'b0;
    logic        cache_rnw = 1'b0;
    logic [12:0] cache_addr = '0;
    logic [63:0] cache_wdata = '0;
    logic        ram_ack = 1'b0;
    logic [15:0] ram_rdata_a = '0, ram_rdata_b = '0;

    logic        cache_ready_a, cache_ack_a, cache_err_a, ram_avalid_a, ram_rnw_a;
    logic [63:0] cache_rdata_a;
    logic [12:0] ram_addr_a;
    logic [15:0] ram_wdata_a;
    logic        cache_ready_b, cache_ack_b, cache_err_b, ram_avalid_b, ram_rnw_b;
    logic [63:0] cache_rdata_b;
    logic [12:0] ram_addr_b;
    logic [15:0] ram_wdata_b;

    always #5 clk = ~clk;

    ram_line_xfer #(.CWF(1), .TIMEOUT(TMO)) dut_a (
        .clk(clk), .not_reset(not_reset),
        .cache_avalid(cache_avalid), .cache_rnw(cache_rnw), .cache_addr(cache_addr),
        .cache_wdata(cache_wdata), .cache_ready(cache_ready_a), .cache_rdata(cache_rdata_a),
        .cache_ack(cache_ack_a), .cache_err(cache_err_a),
        .ram_rdata(ram_rdata_a), .ram_ack(ram_ack), .ram_avalid(ram_avalid_a),
        .ram_rnw(ram_rnw_a), .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a)
    );

    ram_line_xfer #(.CWF(0), .TIMEOUT(TMO)) dut_b (
        .clk(clk), .not_reset(not_reset),
        .cache_avalid(cache_avalid), .cache_rnw(cache_rnw), .cache_addr(cache_addr),
        .cache_wdata(cache_wdata), .cache_ready(cache_ready_b), .cache_rdata(cache_rdata_b),
        .cache_ack(cache_ack_b), .cache_err(cache_err_b),
        .ram_rdata(ram_rdata_b), .ram_ack(ram_ack), .ram_avalid(ram_avalid_b),
        .ram_rnw(ram_rnw_b), .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b)
    );

    typedef struct {
        logic        rnw;
        logic [12:0] addr;
        logic [63:0] wdata;
        int          delay;
        int          tw;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } txn_t;

    txn_t        qa[$], qb[$];
    logic [15:0] model_mem [8192];
    logic [15:0] mem_a [8192];
    logic [15:0] mem_b [8192];
    logic [63:0] last_rdata = '0;
    int          checks = 0, errors = 0;
    int          wi_a = 0, wi_b = 0, wc = 0, n_done = 0;
    bit          prev_av = 0, gap_pend = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    // Expected word address/data from the request itself: base | ((start + i) mod 4).
    task automatic word_chk(input string tag, input txn_t t, input int wi, input bit cwf,
                            input logic rnw_o, input logic [12:0] addr_o, input logic [15:0] wd_o);
        int start, off;
        start = (t.rnw && cwf) ? int'(t.addr[1:0]) : 0;
        off = (start + wi) % 4;
        chk({tag, "_rnw"}, rnw_o, t.rnw);
        chk({tag, "_addr"}, addr_o, {t.addr[12:2], 2'(off)});
        if (!t.rnw)
            chk({tag, "_wdata"}, wd_o, t.wdata[off*16 +: 16]);
    endtask

    task automatic model_add(input logic rnw, input logic [12:0] addr, input logic [63:0] wdata,
                             input int delay, input int tw);
        txn_t        t;
        logic [12:0] base;
        logic [63:0] line;
        base = {addr[12:2], 2'b00};
        line = '0;
        t.rnw = rnw; t.addr = addr; t.wdata = wdata; t.delay = delay; t.tw = tw;
        t.exp_err = (tw >= 0);
        if (rnw) begin
            if (tw < 0) begin
                for (int k = 0; k < 4; k++)
                    line[k*16 +: 16] = model_mem[base + 13'(k)];
                last_rdata = line;
            end
        end else begin
            for (int k = 0; k < 4; k++)
                if (tw < 0 || k < tw)
                    model_mem[base + 13'(k)] = wdata[k*16 +: 16];
        end
        t.exp_rdata = last_rdata;
        qa.push_back(t);
        qb.push_back(t);
    endtask

    task automatic push(input logic rnw, input logic [12:0] addr, input logic [63:0] wdata,
                        input int delay, input int tw);
        int n = 0;
        while (!cache_ready_a && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!cache_ready_a) begin
            chk("ready_wait", cache_ready_a, 1);
            return;
        end
        cache_avalid = 1'b1;
        cache_rnw    = rnw;
        cache_addr   = addr;
        cache_wdata  = wdata;
        model_add(rnw, addr, wdata, delay, tw);
        @(negedge clk);
        cache_avalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", qa.size() + qb.size(), 0);
        @(negedge clk);
    endtask

    // RAM responder and word/completion scoreboard.
    initial begin : mon
        txn_t t;
        forever begin
            @(negedge clk);
            if (!not_reset) begin
                qa.delete(); qb.delete();
                wi_a = 0; wi_b = 0; wc = 0;
                prev_av = 0; gap_pend = 0; ram_ack = 1'b0;
                continue;
            end
            if (gap_pend) begin
                chk("regap", ram_avalid_a, 1);
                gap_pend = 0;
            end
            if (ram_ack) begin
                chk("gap", ram_avalid_a, 0);
                wi_a++; wi_b++; wc = 0;
                gap_pend = (wi_a < 4);
            end else if (prev_av && !ram_avalid_a) begin
                chk("tmo_len", wc, TMO);
                wc = 0;
            end
            if (cache_ack_a) begin
                if (qa.size() == 0) chk("ack_a_spurious", cache_ack_a, 0);
                else begin
                    t = qa.pop_front();
                    chk("err_a", cache_err_a, t.exp_err);
                    chk("rdata_a", cache_rdata_a, t.exp_rdata);
                    chk("nwords_a", wi_a, (t.tw < 0) ? 4 : t.tw);
                    wi_a = 0;
                    n_done++;
                end
            end
            if (cache_ack_b) begin
                if (qb.size() == 0) chk("ack_b_spurious", cache_ack_b, 0);
                else begin
                    t = qb.pop_front();
                    chk("err_b", cache_err_b, t.exp_err);
                    chk("rdata_b", cache_rdata_b, t.exp_rdata);
                    wi_b = 0;
                end
            end
            prev_av = ram_avalid_a;
            ram_ack = 1'b0;
            if (ram_avalid_a) begin
                if (qa.size() == 0 || qb.size() == 0) chk("req_no_txn", ram_avalid_a, 0);
                else begin
                    t = qa[0];
                    if (wi_a != t.tw && wc >= t.delay) begin
                        word_chk("wa", t, wi_a, 1, ram_rnw_a, ram_addr_a, ram_wdata_a);
                        word_chk("wb", qb[0], wi_b, 0, ram_rnw_b, ram_addr_b, ram_wdata_b);
                        chk("avalid_b", ram_avalid_b, 1);
                        ram_rdata_a = mem_a[ram_addr_a];
                        ram_rdata_b = mem_b[ram_addr_b];
                        if (!ram_rnw_a) mem_a[ram_addr_a] = ram_wdata_a;
                        if (!ram_rnw_b) mem_b[ram_addr_b] = ram_wdata_b;
                        ram_ack = 1'b1;
                    end else begin
                        wc++;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int  n, d0;
        bit  seen;
        for (int i = 0; i < 8192; i++) begin
            model_mem[i] = 16'(i);
            mem_a[i]     = 16'(i);
            mem_b[i]     = 16'(i);
        end

        repeat (2) @(negedge clk);
        chk("rst_rdata", cache_rdata_a, 64'h0);
        chk("rst_ack", cache_ack_a, 0);
        chk("rst_err", cache_err_a, 0);
        chk("rst_avalid", ram_avalid_a, 0);
        chk("rst_rnw", ram_rnw_a, 0);
        chk("rst_addr", ram_addr_a, 0);
        chk("rst_wdata", ram_wdata_a, 0);
        chk("rst_ready_a", cache_ready_a, 1);
        chk("rst_ready_b", cache_ready_b, 1);
        not_reset = 1'b1;
        @(negedge clk);

        // Critical-word-first read (A) and offset-0 read (B) of the same line.
        push(1'b1, 13'h0A6, 64'h0, 0, -1);
        drain();
        chk("cwf_rdata_a", cache_rdata_a, 64'h00A7_00A6_00A5_00A4);
        chk("ofs0_rdata_b", cache_rdata_b, 64'h00A7_00A6_00A5_00A4);

        // Zero-wait write with latency measurement from the push edge.
        push(1'b0, 13'h0A5, 64'h4444_3333_2222_1111, 0, -1);
        n = 0;
        while (!cache_ack_a && n < 40) begin
            if (n == 0) chk("lat_av0", ram_avalid_a, 0);
            if (n == 1) chk("lat_av1", ram_avalid_a, 1);
            @(negedge clk);
            n++;
        end
        chk("wr_latency", n, 8);
        chk("wr_err", cache_err_a, 0);
        drain();
        push(1'b1, 13'h0A5, 64'h0, 1, -1);
        drain();
        chk("wr_readback", cache_rdata_a, 64'h4444_3333_2222_1111);

        // Three back-to-back requests against slow RAM.
        d0 = n_done;
        push(1'b1, 13'h120, 64'h0, 5, -1);
        push(1'b0, 13'h134, {$urandom, $urandom}, 5, -1);
        push(1'b1, 13'h136, 64'h0, 5, -1);
        chk("bp_full", cache_ready_a, 0);
        drain();
        chk("bp_acks", n_done - d0, 3);

        // Timeouts: read aborted on word 0, write aborted on word 2, then normal traffic.
        push(1'b1, 13'h0A4, 64'h0, 0, 0);
        push(1'b1, 13'h0A7, 64'h0, 1, -1);
        push(1'b0, 13'h140, {$urandom, $urandom}, 0, 2);
        push(1'b1, 13'h142, 64'h0, 2, -1);
        drain();

        // Reset during word 2 with requests still queued.
        push(1'b1, 13'h150, 64'h0, 3, -1);
        push(1'b1, 13'h160, 64'h0, 3, -1);
        push(1'b1, 13'h170, 64'h0, 3, -1);
        n = 0;
        while (!(wi_a == 2 && ram_avalid_a) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_reached", wi_a, 2);
        not_reset = 1'b0;
        #1;
        chk("rst_mid_avalid", ram_avalid_a, 0);
        chk("rst_mid_ack", cache_ack_a, 0);
        chk("rst_mid_ready", cache_ready_a, 1);
        @(negedge clk);
        @(negedge clk);
        not_reset = 1'b1;
        last_rdata = '0;
        @(negedge clk);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (ram_avalid_a || cache_ack_a || ram_avalid_b || cache_ack_b) seen = 1;
        end
        chk("rst_mid_idle", seen, 0);
        chk("rst_mid_rdata", cache_rdata_a, 64'h0);
        push(1'b1, 13'h0A6, 64'h0, 1, -1);
        drain();

        // Randomized mixed traffic over a small address window.
        for (int i = 0; i < 40; i++) begin
            logic        rnw;
            logic [12:0] addr;
            int          tw;
            rnw  = 1'($urandom % 2);
            addr = 13'h100 + 13'($urandom_range(0, 31));
            tw   = ($urandom % 6 == 0) ? int'($urandom_range(0, 3)) : -1;
            push(rnw, addr, {$urandom, $urandom}, int'($urandom_range(0, 3)), tw);
            if ($urandom % 4 == 0)
                repeat ($urandom_range(1, 5)) @(negedge clk);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
